// File: rtl/level_meter_display_arbiter_pkg.sv
// Shared constants for the level meter display path.
//  DEFAULT_WIDTH    : bar array width used by the meter channels and the arbiter
//  DEFAULT_CHANNELS : default number of meter channels sharing one display
//  chan_w(n)        : width of a channel index for n channels (at least 1 bit)
package level_meter_display_arbiter_pkg;

    localparam int DEFAULT_WIDTH    = 32;
    localparam int DEFAULT_CHANNELS = 2;

    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/level_meter_display_arbiter_rr_arbiter.sv
// Round-robin priority rotate, purely combinational.
//  req         : per-requester request flags
//  ptr         : highest-priority index this cycle
//  grant_valid : at least one request present
//  grant_idx   : first requesting index at or after ptr, wrapping modulo N
module rr_arbiter
    import level_meter_display_arbiter_pkg::*;
#(
    parameter int N = 2,
    localparam int W = chan_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         grant_valid,
    output logic [W-1:0] grant_idx
);

    // Walk offsets from farthest to nearest so the nearest requester
    // (lowest offset from ptr) is the last write and wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            int idx;
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx[W-1:0];
            end
        end
    end

endmodule

// File: rtl/level_meter_display_arbiter.sv
// Shares one display-refresh stream between CHANNELS level meter pipelines.
// Each channel has a one-deep slot; full slots are drained round-robin into a
// single output register tagged with the source channel.
//  clk, reset : rising-edge clock, asynchronous active-low reset
//  i_valid    : per-channel array valid
//  i_ready    : per-channel slot free (straight from the full flags)
//  i_array    : channel c bar array at [c*WIDTH +: WIDTH]
//  o_valid    : output array valid, held until o_ready
//  o_ready    : downstream driver accepts output
//  o_channel  : source channel of o_array
//  o_array    : bar array
//  o_sweep    : marks the first beat of each round-robin sweep
module level_meter_display_arbiter
    import level_meter_display_arbiter_pkg::*;
#(
    parameter int CHANNELS = DEFAULT_CHANNELS,
    parameter int WIDTH    = DEFAULT_WIDTH,
    localparam int CW      = chan_w(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       i_valid,
    output logic [CHANNELS-1:0]       i_ready,
    input  logic [CHANNELS*WIDTH-1:0] i_array,
    output logic                      o_valid,
    input  logic                      o_ready,
    output logic [CW-1:0]             o_channel,
    output logic [WIDTH-1:0]          o_array,
    output logic                      o_sweep
);

    logic [CHANNELS-1:0][WIDTH-1:0] slot_data;
    logic [CHANNELS-1:0]            slot_full;
    logic [CW-1:0]                  ptr;
    logic [CW-1:0]                  last_g;
    logic                           first_pending;

    logic                           grant_valid;
    logic [CW-1:0]                  grant_idx;
    logic                           out_free;
    logic                           load;
    logic [CW-1:0]                  ptr_next;

    rr_arbiter #(.N(CHANNELS)) u_arb (
        .req         (slot_full),
        .ptr         (ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Ready comes only from the full flags, so o_ready never reaches i_ready
    // combinationally; a slot drained this cycle accepts again next cycle.
    assign i_ready  = ~slot_full;
    assign out_free = ~o_valid | o_ready;
    assign load     = out_free & grant_valid;
    assign ptr_next = (grant_idx == CW'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;

    // Accept and drain of one slot are mutually exclusive: accept needs the
    // slot empty, grant needs it full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_full <= '0;
            slot_data <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (load && grant_idx == CW'(c)) begin
                    slot_full[c] <= 1'b0;
                end else if (i_valid[c] && !slot_full[c]) begin
                    slot_full[c] <= 1'b1;
                    slot_data[c] <= i_array[c*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Output register: reloads whenever it is empty or being consumed, so a
    // stream of full slots drains one per cycle with no bubbles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_valid       <= 1'b0;
            o_channel     <= '0;
            o_array       <= '0;
            o_sweep       <= 1'b0;
            ptr           <= '0;
            last_g        <= '0;
            first_pending <= 1'b1;
        end else if (out_free) begin
            o_valid <= grant_valid;
            if (grant_valid) begin
                o_channel     <= grant_idx;
                o_array       <= slot_data[grant_idx];
                // A grant at or below the previous one means the pointer wrapped.
                o_sweep       <= first_pending | (grant_idx <= last_g);
                ptr           <= ptr_next;
                last_g        <= grant_idx;
                first_pending <= 1'b0;
            end else begin
                o_sweep <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_level_meter_display_arbiter.sv
module tb_level_meter_display_arbiter;

    localparam int CH = 4;
    localparam int W  = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [CH-1:0]   i_valid;
    logic [CH-1:0]   i_ready;
    logic [CH*W-1:0] i_array;
    logic            o_valid;
    logic            o_ready;
    logic [1:0]      o_channel;
    logic [W-1:0]    o_array;
    logic            o_sweep;

    always #5 clk = ~clk;

    level_meter_display_arbiter #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_array   (i_array),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_channel (o_channel),
        .o_array   (o_array),
        .o_sweep   (o_sweep)
    );

    typedef struct packed {
        logic [1:0]   ch;
        logic [W-1:0] data;
        logic         sweep;
    } beat_t;

    beat_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_beat(input logic [1:0] ch, input logic [W-1:0] data, input logic sweep);
        beat_t b;
        b.ch    = ch;
        b.data  = data;
        b.sweep = sweep;
        exp_q.push_back(b);
    endtask

    // Present the masked channels together; each drops its valid once accepted.
    task automatic offer(input logic [3:0] mask, input logic [W-1:0] d0, input logic [W-1:0] d1,
                         input logic [W-1:0] d2, input logic [W-1:0] d3);
        logic [3:0] acc;
        int         n;
        i_array = {d3, d2, d1, d0};
        i_valid = mask;
        n = 0;
        while (i_valid != 4'b0 && n < 100) begin
            @(negedge clk);
            acc = i_valid & i_ready;
            @(posedge clk);
            #1;
            i_valid = i_valid & ~acc;
            n++;
        end
        check("offer accepted", {28'b0, i_valid}, 32'h0);
        i_valid = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_valid) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain pending beats", exp_q.size(), 32'h0);
    endtask

    // Monitor: every handshake seen away from the edge is scored against the queue.
    always @(negedge clk) begin
        if (reset === 1'b1 && o_valid === 1'b1 && o_ready === 1'b1) begin
            beat_t e;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected beat: got ch%0d %h expected none", o_channel, o_array);
            end else begin
                e = exp_q.pop_front();
                check("beat channel", {30'b0, o_channel}, {30'b0, e.ch});
                check("beat array", o_array, e.data);
                check("beat sweep", {31'b0, o_sweep}, {31'b0, e.sweep});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        i_valid = '1;
        i_array = '0;
        o_ready = 1'b1;

        // Reset state while inputs are offered
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset i_ready", {28'b0, i_ready}, 32'hF);
        check("reset o_valid", {31'b0, o_valid}, 32'h0);
        check("reset o_array", o_array, 32'h0);
        check("reset o_channel", {30'b0, o_channel}, 32'h0);
        check("reset o_sweep", {31'b0, o_sweep}, 32'h0);
        i_valid = '0;
        reset   = 1'b1;
        @(posedge clk);
        #1;

        // Single channel: first grant after reset carries sweep
        expect_beat(2'd1, 32'h0000_FFFF, 1'b1);
        offer(4'b0010, 0, 32'h0000_FFFF, 0, 0);
        @(posedge clk);
        #1;
        check("latency o_valid", {31'b0, o_valid}, 32'h1);
        check("latency o_channel", {30'b0, o_channel}, 32'h1);
        drain();

        // Two channels loaded together, ptr=2 wraps to ch0
        expect_beat(2'd0, 32'h0000_000F, 1'b1);
        expect_beat(2'd1, 32'h0000_00FF, 1'b0);
        offer(4'b0011, 32'h0000_000F, 32'h0000_00FF, 0, 0);
        drain();

        // Continuous offers alternate 0,1 with sweep on each ch0
        for (int k = 0; k < 3; k++) begin
            expect_beat(2'd0, 32'h1000 + k, 1'b1);
            expect_beat(2'd1, 32'h2000 + k, 1'b0);
            offer(4'b0011, 32'h1000 + k, 32'h2000 + k, 0, 0);
        end
        drain();

        // Backpressure: output held, slot refilled and blocked
        o_ready = 1'b0;
        expect_beat(2'd0, 32'hAAAA, 1'b1);
        expect_beat(2'd0, 32'hBBBB, 1'b1);
        offer(4'b0001, 32'hAAAA, 0, 0, 0);
        offer(4'b0001, 32'hBBBB, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold o_valid", {31'b0, o_valid}, 32'h1);
            check("hold o_array", o_array, 32'hAAAA);
            check("hold o_channel", {30'b0, o_channel}, 32'h0);
            check("hold i_ready0", {31'b0, i_ready[0]}, 32'h0);
        end
        @(posedge clk);
        #1;
        o_ready = 1'b1;
        drain();

        // Fairness: ch3 joins a ch0 stream and is served on the next load
        expect_beat(2'd0, 32'h100, 1'b1);
        offer(4'b0001, 32'h100, 0, 0, 0);
        expect_beat(2'd0, 32'h101, 1'b1);
        offer(4'b0001, 32'h101, 0, 0, 0);
        expect_beat(2'd3, 32'h3333, 1'b0);
        expect_beat(2'd0, 32'h102, 1'b1);
        offer(4'b1001, 32'h102, 0, 0, 32'h3333);
        expect_beat(2'd0, 32'h103, 1'b1);
        offer(4'b0001, 32'h103, 0, 0, 0);
        drain();

        // Three channels at once from ptr=1, then a wrap with ch0/ch2
        expect_beat(2'd1, 32'hA1, 1'b0);
        expect_beat(2'd2, 32'hA2, 1'b0);
        expect_beat(2'd3, 32'hA3, 1'b0);
        offer(4'b1110, 0, 32'hA1, 32'hA2, 32'hA3);
        drain();
        expect_beat(2'd0, 32'hB0, 1'b1);
        expect_beat(2'd2, 32'hB2, 1'b0);
        offer(4'b0101, 32'hB0, 0, 32'hB2, 0);
        drain();

        // Reset mid-operation: buffered arrays are discarded
        o_ready = 1'b0;
        offer(4'b0001, 32'hDEAD, 0, 0, 0);
        offer(4'b0010, 0, 32'hBEEF, 0, 0);
        @(negedge clk);
        check("pre-reset o_valid", {31'b0, o_valid}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("async reset o_valid", {31'b0, o_valid}, 32'h0);
        check("async reset i_ready", {28'b0, i_ready}, 32'hF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset   = 1'b1;
        o_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("post-reset idle", {31'b0, o_valid}, 32'h0);
        @(posedge clk);
        #1;
        expect_beat(2'd2, 32'h7777, 1'b1);
        offer(4'b0100, 0, 0, 32'h7777, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
